// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: operand forwarding,
// load-use bubble, branch flush, multi-cycle EX hold and a saturating stall counter.
//
// state   | meaning
// IDLE    | normal issue; per-cycle hazards resolved, a multi-cycle op may start
// MC_BUSY | multi-cycle op held in EX; mcCnt = stall cycles still to go
module pipeline_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MultiCycE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             McBusy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam bit         MC_EN   = (MC_LATENCY >= 2);
    localparam logic [3:0] MC_LOAD = MC_EN ? 4'(MC_LATENCY - 2) : 4'd0;

    state_t     state;
    logic [3:0] mcCnt;

    logic lwStall;
    logic mcStart;
    logic mcHold;
    logic idleFree;
    logic brTaken;
    logic lwTaken;
    logic stallAll;
    logic frontStall;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       wrM,
        input logic [4:0] rdW,
        input logic       wrW
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (wrM && (rdM != 5'd0) && (rdM == rs)) begin
            sel = 2'b10;
        end else if (wrW && (rdW != 5'd0) && (rdW == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lwStall    = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mcStart    = (state == IDLE) && MultiCycE && MC_EN;
        mcHold     = (state == MC_BUSY) && (mcCnt != 4'd0);
        idleFree   = (state == IDLE) && !mcStart;
        // a taken branch squashes the load-use bubble: the dependent op is flushed anyway
        brTaken    = idleFree && PCSrcE;
        lwTaken    = idleFree && lwStall && !PCSrcE;
        stallAll   = mcStart || mcHold;
        frontStall = stallAll || lwTaken;
    end

    assign ForwardAE = rst ? fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
    assign ForwardBE = rst ? fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : 2'b00;
    assign StallF    = rst && frontStall;
    assign StallD    = rst && frontStall;
    assign StallE    = rst && stallAll;
    assign FlushM    = rst && stallAll;
    assign FlushD    = rst && brTaken;
    assign FlushE    = rst && (brTaken || lwTaken);
    assign McBusy    = rst && (state == MC_BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mcCnt      <= 4'd0;
            StallCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mcStart) begin
                        state <= MC_BUSY;
                        mcCnt <= MC_LOAD;
                    end
                end
                MC_BUSY: begin
                    if (mcCnt != 4'd0) begin
                        mcCnt <= mcCnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (frontStall && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline; it drives forwarding selects into the execute-stage operand muxes and the stall/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves three hazard types: RAW hazards via forwarding, load-use hazards via a one-cycle bubble, and taken branches/jumps via flushes.
- Holds a multi-cycle execute operation (iterative mul/div) in EX for MC_LATENCY cycles through a small FSM.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies EX (legal values 1..15; 1 means no stall)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
Rs1D  input  5  source reg 1 of instruction in decode
Rs2D  input  5  source reg 2 of instruction in decode
Rs1E  input  5  source reg 1 of instruction in execute
Rs2E  input  5  source reg 2 of instruction in execute
RdE  input  5  dest reg in execute
RdM  input  5  dest reg in memory
RdW  input  5  dest reg in writeback
RegWriteM  input  1  memory-stage instruction writes the register file
RegWriteW  input  1  writeback-stage instruction writes the register file
ResultSrcE0  input  1  execute-stage instruction is a load
PCSrcE  input  1  taken branch/jump resolved in execute
MultiCycE  input  1  execute-stage instruction is a multi-cycle op
ForwardAE  output  2  operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  operand B select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  clear EX/MEM controls (insert bubble)
McBusy  output  1  FSM is in MC_BUSY
StallCount  output  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; down-counter to 0; StallCount to 0. All stall, flush and McBusy outputs are 0 and ForwardAE/BE are 00 while reset is asserted. A reset mid multi-cycle op abandons the op.
- Forwarding (combinational, active in every state):
  - ForwardAE=10 when RegWriteM & RdM!=0 & RdM==Rs1E.
  - Otherwise ForwardAE=01 when RegWriteW & RdW!=0 & RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - M has priority over W. Register x0 is never forwarded.
- Load-use: lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). Evaluated only in IDLE. Effect in the same cycle: StallF=1, StallD=1, FlushE=1, giving exactly one bubble.
- Branch: in IDLE, PCSrcE=1 gives FlushD=1 and FlushE=1 in the same cycle. If PCSrcE and lwStall coincide, the branch wins: FlushD=1, FlushE=1, StallF=0, StallD=0.
- FSM IDLE:
  - When MultiCycE=1 and MC_LATENCY>=2: in the same cycle assert StallF, StallD, StallE and FlushM, and suppress lwStall and PCSrcE effects.
  - Next state is MC_BUSY, with the counter loaded to MC_LATENCY-2.
- FSM MC_BUSY:
  - McBusy=1. PCSrcE, MultiCycE and lwStall are ignored. FlushE=0 and FlushD=0.
  - If counter!=0: StallF, StallD, StallE and FlushM asserted; counter decrements.
  - If counter==0: all stalls and FlushM deasserted (EX/MEM captures the result this edge); next state is IDLE.
  - A multi-cycle op therefore stalls the front end for exactly MC_LATENCY-1 cycles. The op still in EX on the release cycle does not retrigger, because the FSM is not in IDLE.
- Back-to-back multi-cycle ops: the following op enters EX after release and is detected in IDLE again. There are no idle cycles between them.
- MC_LATENCY=1: MultiCycE is ignored and the FSM never leaves IDLE.
- StallCount increments on every rising edge where StallF=1. It saturates at all-ones and never wraps.
- Outputs are combinational from state and inputs. The only state held is the FSM, the counter and StallCount.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. Then Rs2E=0 with RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. With RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 and lwStall condition true in the same cycle -> FlushD=FlushE=1, StallF=0.
- Multi-cycle with MC_LATENCY=4: MultiCycE held 1 -> StallF/StallD/StallE/FlushM=1 for 3 cycles and McBusy=1 for 2 of them; 4th cycle releases. StallCount +3. A PCSrcE pulse during busy is ignored.
- Reset mid-op: rst low during MC_BUSY -> McBusy=0, all stalls 0, StallCount=0 immediately. After release, a fresh op stalls a full 3 cycles.
- Saturation: with CNT_W=4, drive 20 load-use stalls -> StallCount stops at 15.
